// File: rtl/census_cost_pipe_if.sv
// Beat-level handshake bundle for census_cost_pipe: input beat (a, b, mode)
// with valid/ready, and result beat (per-lane costs, min, argmin) with valid/ready.
interface census_cost_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned CHUNK = 8
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*CW-1:0]   out_cost;
    logic [CW-1:0]         out_min;
    logic [IW-1:0]         out_min_idx;

    // Block side
    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_cost, out_min, out_min_idx
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_cost, out_min, out_min_idx
    );
endinterface

// File: rtl/census_cost_pipe.sv
// Pipelined multi-lane popcount / Hamming-distance engine with a registered
// per-beat argmin. Stages: S0 input reg, S1 chunk counts, one adder-tree level
// per stage, then argmin. Latency is 3 + clog2(ceil(WIDTH/CHUNK)) edges.
// Flow control is a global stall driven from the output handshake.
module census_cost_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned CHUNK = 8
) (
    input logic               clk,
    input logic               rst,
    census_cost_pipe_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned NC = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PW = NC * CHUNK;
    localparam int unsigned LV = $clog2(NC);
    // Tree rows are twice the chunk count so pair reads never go out of range;
    // entries beyond a level's live operand count stay zero, which lets an odd
    // leftover operand pass through by being added to zero.
    localparam int unsigned TS = 2 * NC;

    logic                   w_advance;

    logic                   r_s0_valid;
    logic                   r_s0_mode;
    logic [LANES*WIDTH-1:0] r_s0_a;
    logic [LANES*WIDTH-1:0] r_s0_b;

    logic [CW-1:0]          w_chunk [0:LANES-1][0:NC-1];

    logic                   r_tv    [0:LV];
    logic [CW-1:0]          r_tree  [0:LV][0:LANES-1][0:TS-1];

    logic [CW-1:0]          w_min;
    logic [IW-1:0]          w_idx;

    logic                   r_out_valid;
    logic [LANES*CW-1:0]    r_out_cost;
    logic [CW-1:0]          r_out_min;
    logic [IW-1:0]          r_out_idx;

    assign w_advance       = !r_out_valid || bus.out_ready;
    // Held high during reset so the producer never sees a stale stall.
    assign bus.in_ready    = w_advance || !rst;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_cost    = r_out_cost;
    assign bus.out_min     = r_out_min;
    assign bus.out_min_idx = r_out_idx;

    // S0: capture the input beat; valid only on an actual accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_a     <= '0;
            r_s0_b     <= '0;
        end else if (w_advance) begin
            r_s0_valid <= bus.in_valid && bus.in_ready;
            r_s0_mode  <= bus.in_mode;
            r_s0_a     <= bus.in_a;
            r_s0_b     <= bus.in_b;
        end
    end

    // Per-lane operand select and zero-padded chunk popcounts feeding S1
    always_comb begin
        logic [WIDTH-1:0] w_x;
        logic [PW-1:0]    w_pad;
        logic [CW-1:0]    w_cnt;
        w_x   = '0;
        w_pad = '0;
        w_cnt = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_x   = r_s0_mode ? (r_s0_a[l*WIDTH +: WIDTH] ^ r_s0_b[l*WIDTH +: WIDTH])
                              : r_s0_a[l*WIDTH +: WIDTH];
            w_pad = PW'(w_x);
            for (int unsigned c = 0; c < NC; c++) begin
                w_cnt = '0;
                for (int unsigned b = 0; b < CHUNK; b++) begin
                    w_cnt = w_cnt + CW'(w_pad[c*CHUNK + b]);
                end
                w_chunk[l][c] = w_cnt;
            end
        end
    end

    // S1 chunk counts and one registered adder-tree level per following stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k <= LV; k++) begin
                r_tv[k] <= 1'b0;
                for (int unsigned l = 0; l < LANES; l++) begin
                    for (int unsigned j = 0; j < TS; j++) begin
                        r_tree[k][l][j] <= '0;
                    end
                end
            end
        end else if (w_advance) begin
            r_tv[0] <= r_s0_valid;
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned c = 0; c < NC; c++) begin
                    r_tree[0][l][c] <= w_chunk[l][c];
                end
            end
            for (int unsigned k = 1; k <= LV; k++) begin
                r_tv[k] <= r_tv[k-1];
                for (int unsigned l = 0; l < LANES; l++) begin
                    for (int unsigned j = 0; j < NC; j++) begin
                        r_tree[k][l][j] <= r_tree[k-1][l][2*j] + r_tree[k-1][l][2*j+1];
                    end
                end
            end
        end
    end

    // Argmin over final lane costs: strict less-than from lane 0, lowest index wins ties
    always_comb begin
        w_min = r_tree[LV][0][0];
        w_idx = '0;
        for (int unsigned l = 1; l < LANES; l++) begin
            if (r_tree[LV][l][0] < w_min) begin
                w_min = r_tree[LV][l][0];
                w_idx = IW'(l);
            end
        end
    end

    // Output stage: lane costs, minimum and its index
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_cost  <= '0;
            r_out_min   <= '0;
            r_out_idx   <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_tv[LV];
            for (int unsigned l = 0; l < LANES; l++) begin
                r_out_cost[l*CW +: CW] <= r_tree[LV][l][0];
            end
            r_out_min <= w_min;
            r_out_idx <= w_idx;
        end
    end
endmodule

// File: tb/tb_census_cost_pipe.sv
// Scoreboard bench for census_cost_pipe: default-parameter instance driven
// with directed and random beats, plus a WIDTH=13/CHUNK=4/LANES=3 instance.
module tb_census_cost_pipe;
    localparam int LAT0 = 5;   // 3 + clog2(32/8)
    localparam int LAT1 = 5;   // 3 + clog2(ceil(13/4))

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    census_cost_pipe_if #(.WIDTH(32), .LANES(4), .CHUNK(8)) bus0 ();
    census_cost_pipe_if #(.WIDTH(13), .LANES(3), .CHUNK(4)) bus1 ();

    census_cost_pipe #(.WIDTH(32), .LANES(4), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    census_cost_pipe #(.WIDTH(13), .LANES(3), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic [23:0] cost;
        logic [5:0]  mn;
        logic [1:0]  idx;
        int          acc;
        int          stl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_total = 0;
    logic bp_en = 1'b0;
    logic hold = 1'b0;
    logic [23:0] last_cost;
    logic [5:0]  last_min;
    logic [1:0]  last_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per-lane Hamming weight, then first lane holding the smallest weight
    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b, input logic m);
        exp_t e;
        int   c [4];
        logic [31:0] x;
        int   best;
        for (int l = 0; l < 4; l++) begin
            x = m ? (a[l*32 +: 32] ^ b[l*32 +: 32]) : a[l*32 +: 32];
            c[l] = $countones(x);
            e.cost[l*6 +: 6] = 6'(c[l]);
        end
        best = 0;
        for (int l = 1; l < 4; l++) if (c[l] < c[best]) best = l;
        e.mn  = 6'(c[best]);
        e.idx = 2'(best);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    // Monitor: samples on the falling edge, predicts accepts, checks results
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            sb.delete();
            hold = 1'b0;
        end else begin
            check("in_ready", 64'(bus0.in_ready), 64'(!bus0.out_valid || bus0.out_ready));
            if (bus0.out_valid === 1'b1) begin
                if (hold) begin
                    check("hold_cost", 64'(bus0.out_cost), 64'(last_cost));
                    check("hold_min", 64'(bus0.out_min), 64'(last_min));
                    check("hold_idx", 64'(bus0.out_min_idx), 64'(last_idx));
                end else if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got cost=%h min=%0d idx=%0d, expected no beat",
                             bus0.out_cost, bus0.out_min, bus0.out_min_idx);
                end else begin
                    e = sb.pop_front();
                    check("cost", 64'(bus0.out_cost), 64'(e.cost));
                    check("min", 64'(bus0.out_min), 64'(e.mn));
                    check("min_idx", 64'(bus0.out_min_idx), 64'(e.idx));
                    check("latency", 64'(cyc - 1), 64'(e.acc + LAT0 - 1 + (stall_total - e.stl)));
                end
                last_cost = bus0.out_cost;
                last_min  = bus0.out_min;
                last_idx  = bus0.out_min_idx;
            end
            hold = (bus0.out_valid === 1'b1) && (bus0.out_ready === 1'b0);
            if (hold) stall_total++;
            if (bus0.in_valid === 1'b1 && bus0.in_ready === 1'b1) begin
                e = model(bus0.in_a, bus0.in_b, bus0.in_mode);
                e.acc = cyc;
                e.stl = stall_total;
                sb.push_back(e);
            end
        end
        cyc++;
    end

    // Consumer: always ready, or pseudo-random backpressure
    initial begin
        bus0.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus0.out_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Present a beat and hold it until accepted; returns just after the accept edge
    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic m);
        logic acc;
        bus0.in_valid = 1'b1;
        bus0.in_a     = a;
        bus0.in_b     = b;
        bus0.in_mode  = m;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no accept in 500 cycles, expected accept");
    endtask

    task automatic idle(input int n);
        bus0.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus0.in_a    = {$urandom, $urandom, $urandom, $urandom};
            bus0.in_b    = {$urandom, $urandom, $urandom, $urandom};
            bus0.in_mode = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (sb.size() == 0 && bus0.out_valid !== 1'b1) break;
            idle(1);
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic rand_beat();
        send({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    // One beat on the 13-bit instance with fixed expectations
    task automatic run1(input logic [38:0] a, input logic [38:0] b, input logic m,
                        input logic [11:0] ec, input logic [3:0] em, input logic [1:0] ei);
        int edges;
        bus1.in_valid = 1'b1;
        bus1.in_a     = a;
        bus1.in_b     = b;
        bus1.in_mode  = m;
        @(negedge clk);
        check("w13_in_ready", 64'(bus1.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        edges = 1;
        while (bus1.out_valid !== 1'b1 && edges < 12) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("w13_latency", 64'(edges), 64'(LAT1));
        check("w13_cost", 64'(bus1.out_cost), 64'(ec));
        check("w13_min", 64'(bus1.out_min), 64'(em));
        check("w13_idx", 64'(bus1.out_min_idx), 64'(ei));
        @(posedge clk);
        #1;
        check("w13_one_beat", 64'(bus1.out_valid), 64'(0));
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_mode = 1'b0; bus0.in_a = '0; bus0.in_b = '0;
        bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
        bus1.out_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus0.out_valid), 64'(0));
        check("rst_out_cost", 64'(bus0.out_cost), 64'(0));
        check("rst_out_min", 64'(bus0.out_min), 64'(0));
        check("rst_out_idx", 64'(bus0.out_min_idx), 64'(0));
        check("rst_in_ready", 64'(bus0.in_ready), 64'(1));
        check("w13_rst_out_valid", 64'(bus1.out_valid), 64'(0));
        check("w13_rst_out_cost", 64'(bus1.out_cost), 64'(0));
        rst = 1'b1;

        // Directed popcount: costs {0, 32, 4, 2}, min 0 at lane 0
        send({32'h80000001, 32'h0000000F, 32'hFFFFFFFF, 32'h00000000}, '0, 1'b0);
        idle(8);
        // Directed XOR with a tie: costs {32, 1, 0, 0}, min 0 at lane 2
        send({4{32'hF0F0F0F0}},
             {32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F1, 32'h0F0F0F0F}, 1'b1);
        idle(8);

        // Back-to-back stream
        for (int i = 0; i < 20; i++) rand_beat();
        drain();

        // Backpressure with input bubbles
        bp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            rand_beat();
        end
        drain();
        bp_en = 1'b0;
        idle(2);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) rand_beat();
        bus0.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(bus0.in_ready), 64'(1));
        rst = 1'b1;
        check("midrst_out_valid", 64'(bus0.out_valid), 64'(0));
        check("midrst_out_cost", 64'(bus0.out_cost), 64'(0));
        check("midrst_out_min", 64'(bus0.out_min), 64'(0));
        check("midrst_out_idx", 64'(bus0.out_min_idx), 64'(0));
        idle(10);
        rand_beat();
        drain();

        // 13-bit / 4-bit-chunk / 3-lane instance
        run1({3{13'h1FFF}}, '0, 1'b0, {4'd13, 4'd13, 4'd13}, 4'd13, 2'd0);
        run1({3{13'h1FFF}}, {13'h1FFF, 13'h1FFE, 13'h0000}, 1'b1, {4'd0, 4'd1, 4'd13}, 4'd0, 2'd2);
        run1({13'h0007, 13'h0700, 13'h001F}, '0, 1'b0, {4'd3, 4'd3, 4'd5}, 4'd3, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule
